// File: rtl/syscall_sequencer_if.sv
// Decoder/memory/console handshake bundle for the syscall sequencer.
// master = surrounding core (decoder, memory, console); slave = the sequencer.
interface syscall_sequencer_if;
  logic        syscall_req;
  logic [31:0] vreg;
  logic [31:0] areg;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        stall;
  logic        done;
  logic        err;
  logic        halted;

  modport master (
    output syscall_req, vreg, areg, mem_ack, mem_rdata, char_ready,
    input  mem_req, mem_addr, char_valid, char_data, stall, done, err, halted
  );

  modport slave (
    input  syscall_req, vreg, areg, mem_ack, mem_rdata, char_ready,
    output mem_req, mem_addr, char_valid, char_data, stall, done, err, halted
  );
endinterface

// File: rtl/syscall_sequencer.sv
// MIPS syscall service unit: puts (4), putchar (11), hex print (34), exit (10).
// Optional SYSCALL_TRACE_EN adds simulation-only tracing and $finish after exit.
module syscall_sequencer #(
  parameter int unsigned MAX_LEN = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  syscall_sequencer_if.slave  bus
);
  // counter doubles as nibble index in hex mode, so it must reach 8 too
  localparam int unsigned CNT_MAX = (MAX_LEN > 8) ? MAX_LEN : 8;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, DISPATCH, FETCH, SCAN, EMIT, DONE, HALT} state_t;
  typedef enum logic [1:0] {M_PUTS, M_CHAR, M_HEX} mode_t;

  state_t        state_q;
  mode_t         mode_q;
  logic [31:0]   code_q, arg_q, ptr_q, word_q, mem_addr_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    char_q;
  logic          mem_req_q, char_valid_q, done_q, err_q, halted_q;
  logic [31:0]   ptr_d;
  logic [7:0]    scan_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  assign ptr_d = ptr_q + 32'd1;

  // big-endian: byte offset 0 lives in bits 31:24
  always_comb begin
    scan_byte = word_q[31:24];
    case (ptr_q[1:0])
      2'd1:    scan_byte = word_q[23:16];
      2'd2:    scan_byte = word_q[15:8];
      2'd3:    scan_byte = word_q[7:0];
      default: scan_byte = word_q[31:24];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= M_PUTS;
      code_q       <= '0;
      arg_q        <= '0;
      ptr_q        <= '0;
      word_q       <= '0;
      mem_addr_q   <= '0;
      cnt_q        <= '0;
      char_q       <= '0;
      mem_req_q    <= 1'b0;
      char_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (bus.syscall_req) begin
          code_q  <= bus.vreg;
          arg_q   <= bus.areg;
          state_q <= DISPATCH;
        end
        DISPATCH: case (code_q)
          32'd4: begin
            mode_q     <= M_PUTS;
            ptr_q      <= arg_q;
            cnt_q      <= '0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= {arg_q[31:2], 2'b00};
            state_q    <= FETCH;
          end
          32'd11: begin
            mode_q       <= M_CHAR;
            char_q       <= arg_q[7:0];
            char_valid_q <= 1'b1;
            state_q      <= EMIT;
          end
          32'd34: begin
            mode_q       <= M_HEX;
            char_q       <= hex_char(arg_q[31:28]);
            arg_q        <= {arg_q[27:0], 4'h0};
            cnt_q        <= CW'(1);
            char_valid_q <= 1'b1;
            state_q      <= EMIT;
          end
          32'd10: begin
            halted_q <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= HALT;
          end
          default: begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= DONE;
          end
        endcase
        FETCH: if (bus.mem_ack) begin
          word_q    <= bus.mem_rdata;
          mem_req_q <= 1'b0;
          state_q   <= SCAN;
        end
        SCAN: begin
          if (scan_byte == 8'h00) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (cnt_q == CW'(MAX_LEN)) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            char_q       <= scan_byte;
            char_valid_q <= 1'b1;
            state_q      <= EMIT;
          end
        end
        EMIT: if (bus.char_ready) begin
          char_valid_q <= 1'b0;
          case (mode_q)
            M_PUTS: begin
              ptr_q <= ptr_d;
              cnt_q <= cnt_q + CW'(1);
              // crossing into a new word needs a refetch, including 2^32 wrap
              if (ptr_d[1:0] == 2'b00) begin
                mem_req_q  <= 1'b1;
                mem_addr_q <= {ptr_d[31:2], 2'b00};
                state_q    <= FETCH;
              end else begin
                state_q <= SCAN;
              end
            end
            M_HEX: begin
              if (cnt_q == CW'(8)) begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                char_valid_q <= 1'b1;
                char_q       <= hex_char(arg_q[31:28]);
                arg_q        <= {arg_q[27:0], 4'h0};
                cnt_q        <= cnt_q + CW'(1);
              end
            end
            default: begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          endcase
        end
        DONE:    state_q <= IDLE;
        HALT:    state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.stall      = ((state_q == IDLE) && bus.syscall_req) ||
                          ((state_q != IDLE) && (state_q != DONE));
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.char_valid = char_valid_q;
  assign bus.char_data  = char_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.halted     = halted_q;

`ifdef SYSCALL_TRACE_EN
  always @(posedge clk) begin
    if (rst_n) begin
      if (state_q == IDLE && bus.syscall_req)
        $display("[%0t] syscall code=%0d arg=0x%08h", $time, bus.vreg, bus.areg);
      if (char_valid_q && bus.char_ready)
        $display("[%0t] char 0x%02h", $time, char_q);
      if (done_q)
        $display("[%0t] done err=%0b halted=%0b", $time, err_q, halted_q);
      if (halted_q)
        $finish;
    end
  end
`endif
endmodule
